// File: rtl/fma_norm_pipe.sv
// Three-stage add / leading-one / normalise pipeline for a fused multiply-add datapath.
// Valid/ready handshake with per-stage stall, synchronous flush and asynchronous reset.
module fma_norm_pipe #(
  parameter int WIDTH  = 74,
  parameter int ANCHOR = 72,
  parameter int SHW    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pm,
  input  logic [WIDTH-1:0] am,
  input  logic             diff_sign,
  input  logic             z_zero,
  input  logic             no_product,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   norm,
  output logic [SHW-1:0]   m_shift,
  output logic             res_sign,
  output logic             res_zero,
  output logic             sticky
);

  localparam int SW = WIDTH + 1;
  localparam int LW = $clog2(SW);

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, s3_adv;

  assign s3_adv   = out_ready | ~out_valid;
  assign s2_adv   = ~s2_valid | s3_adv;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // S1: magnitude add / subtract
  logic [SW-1:0] sum_d;
  logic          sign_d;

  always_comb begin
    sum_d  = '0;
    sign_d = 1'b0;
    if (z_zero && no_product) begin
      sum_d = '0;
    end else if (z_zero) begin
      sum_d = {1'b0, pm};
    end else if (diff_sign) begin
      if (am > pm) begin
        sum_d  = {1'b0, am - pm};
        sign_d = 1'b1;
      end else begin
        sum_d = {1'b0, pm - am};
      end
    end else begin
      sum_d = {1'b0, pm} + {1'b0, am};
    end
  end

  logic [SW-1:0] s1_sum;
  logic          s1_sign;

  // S2: leading-one position and signed shift count
  logic [LW-1:0]  lead;
  logic           zero_d;
  logic [SHW-1:0] shift_d;

  always_comb begin
    lead = '0;
    for (int i = 0; i < SW; i++) begin
      if (s1_sum[i]) lead = LW'(i);
    end
    zero_d  = (s1_sum == '0);
    shift_d = zero_d ? '0 : SHW'(ANCHOR - int'(lead));
  end

  logic [SW-1:0]  s2_sum;
  logic [SHW-1:0] s2_shift;
  logic           s2_sign, s2_zero;

  // S3: a negative count is a right shift; the bits it drops feed sticky
  logic [SHW-1:0] amt;
  logic [SW-1:0]  mask, norm_d;
  logic           sticky_d;

  always_comb begin
    amt      = s2_shift[SHW-1] ? (~s2_shift + SHW'(1)) : s2_shift;
    mask     = (SW'(1) << amt) - SW'(1);
    norm_d   = s2_shift[SHW-1] ? (s2_sum >> amt) : (s2_sum << amt);
    sticky_d = s2_shift[SHW-1] && (|(s2_sum & mask));
  end

  // NOTE: every sequential block uses non-blocking assignments so all stages
  // sample the previous-cycle values of their neighbours on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid  <= in_valid;
      if (s2_adv) s2_valid  <= s1_valid;
      if (s3_adv) out_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_sum   <= '0;
      s1_sign  <= 1'b0;
      s2_sum   <= '0;
      s2_shift <= '0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      norm     <= '0;
      m_shift  <= '0;
      res_sign <= 1'b0;
      res_zero <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      if (s1_adv && in_valid) begin
        s1_sum  <= sum_d;
        s1_sign <= sign_d;
      end
      if (s2_adv && s1_valid) begin
        s2_sum   <= s1_sum;
        s2_shift <= shift_d;
        s2_sign  <= s1_sign & ~zero_d;
        s2_zero  <= zero_d;
      end
      // Output registers only move on a transfer, so a stalled result holds.
      if (s3_adv && s2_valid) begin
        norm     <= norm_d;
        m_shift  <= s2_shift;
        res_sign <= s2_sign;
        res_zero <= s2_zero;
        sticky   <= sticky_d;
      end
    end
  end

endmodule

// File: tb/tb_fma_norm_pipe.sv
// Self-checking bench for fma_norm_pipe at WIDTH=16, ANCHOR=12, SHW=8: directed vectors,
// backpressure, flush, mid-flight reset and randomized traffic against an arithmetic model.
module tb_fma_norm_pipe;

  localparam int WIDTH  = 16;
  localparam int ANCHOR = 12;
  localparam int SHW    = 8;

  typedef struct packed {
    logic [WIDTH:0]   norm;
    logic [SHW-1:0]   ms;
    logic             sign;
    logic             zero;
    logic             sticky;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] pm, am;
  logic             diff_sign, z_zero, no_product, flush;
  logic             out_valid, out_ready;
  logic [WIDTH:0]   norm;
  logic [SHW-1:0]   m_shift;
  logic             res_sign, res_zero, sticky;

  int passed = 0;
  int total  = 0;

  fma_norm_pipe #(.WIDTH(WIDTH), .ANCHOR(ANCHOR), .SHW(SHW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .pm(pm), .am(am), .diff_sign(diff_sign), .z_zero(z_zero), .no_product(no_product),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .norm(norm),
    .m_shift(m_shift), .res_sign(res_sign), .res_zero(res_zero), .sticky(sticky)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, leading one found by powers of two.
  function automatic exp_t model(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] a,
                                 input logic ds, input logic zz, input logic np);
    exp_t r;
    int   s, lead, k;
    r = '0;
    if (zz && np)   s = 0;
    else if (zz)    s = int'(p);
    else if (ds) begin
      if (a > p) begin s = int'(a) - int'(p); r.sign = 1'b1; end
      else       s = int'(p) - int'(a);
    end else        s = int'(p) + int'(a);
    if (s == 0) begin
      r = '0;
      r.zero = 1'b1;
      return r;
    end
    lead = 0;
    for (int i = 0; i <= WIDTH; i++) if (s >= (1 << i)) lead = i;
    r.ms = 8'(ANCHOR - lead);
    if (lead > ANCHOR) begin
      k = lead - ANCHOR;
      r.norm   = 17'(s / (1 << k));
      r.sticky = (s % (1 << k)) != 0;
    end else begin
      r.norm = 17'(s * (1 << (ANCHOR - lead)));
    end
    return r;
  endfunction

  function automatic exp_t observed();
    return {norm, m_shift, res_sign, res_zero, sticky};
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  exp_t q[$];
  exp_t held_vec, e;
  logic held = 1'b0;

  always @(negedge clk) begin
    if (!reset_n || flush) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        total++;
        if (observed() !== held_vec)
          $display("FAIL hold_stable: got %h expected %h", observed(), held_vec);
        else passed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_output: got %h expected none", observed());
        end else begin
          e = q.pop_front();
          if (observed() !== e)
            $display("FAIL scoreboard: got %h expected %h", observed(), e);
          else passed++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(pm, am, diff_sign, z_zero, no_product));
      held     = out_valid && !out_ready;
      held_vec = observed();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] a,
                        input logic ds, input logic zz, input logic np);
    pm = p; am = a; diff_sign = ds; z_zero = zz; no_product = np;
  endtask

  task automatic test_reset();
    repeat (2) step();
    total++;
    if ({out_valid, observed()} !== '0)
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, observed()});
    else passed++;
    reset_n = 1'b1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else passed++;
  endtask

  // One operation through an empty pipe: latency and exact result.
  task automatic run_one(input string name, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] a,
                         input logic ds, input logic zz, input logic np, input exp_t exp);
    out_ready = 1'b1;
    set_op(p, a, ds, zz, np);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL %s_early: got out_valid %b expected 0", name, out_valid);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b1 || observed() !== exp)
      $display("FAIL %s: got v=%b %h expected v=1 %h", name, out_valid, observed(), exp);
    else passed++;
    step();
  endtask

  task automatic test_directed();
    run_one("exact_anchor", 16'h1000, 16'h0000, 1'b0, 1'b0, 1'b0, {17'h01000, 8'h00, 1'b0, 1'b0, 1'b0});
    run_one("carry_right",  16'hF001, 16'hF000, 1'b0, 1'b0, 1'b0, {17'h01E00, 8'hFC, 1'b0, 1'b0, 1'b1});
    run_one("cancel",       16'h1000, 16'h1001, 1'b1, 1'b0, 1'b0, {17'h01000, 8'h0C, 1'b1, 1'b0, 1'b0});
    run_one("exact_cancel", 16'h0ABC, 16'h0ABC, 1'b1, 1'b0, 1'b0, {17'h00000, 8'h00, 1'b0, 1'b1, 1'b0});
    run_one("both_zero",    16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1, {17'h00000, 8'h00, 1'b0, 1'b1, 1'b0});
    run_one("z_zero_only",  16'h0003, 16'h7777, 1'b1, 1'b1, 1'b0, {17'h01800, 8'h0B, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] bp_pm[5], bp_am[5];
    int   idx, guard;
    logic acc;
    for (int i = 0; i < 5; i++) begin
      bp_pm[i] = WIDTH'($urandom_range(1, 16'hFFFF));
      bp_am[i] = WIDTH'($urandom_range(0, 16'hFFFF));
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      set_op(bp_pm[idx], bp_am[idx], 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      total++;
      if (in_ready !== (idx < 3)) $display("FAIL bp_in_ready: got %b expected %b", in_ready, idx < 3);
      else passed++;
      acc = in_ready;
      step();
      if (acc) idx++;
    end
    total++;
    if (out_valid !== 1'b1) $display("FAIL bp_stalled_valid: got %b expected 1", out_valid);
    else passed++;
    out_ready = 1'b1;
    guard = 0;
    while (idx < 5 && guard < 20) begin
      set_op(bp_pm[idx], bp_am[idx], 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      acc = in_ready;
      step();
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    total++;
    if (idx != 5) $display("FAIL bp_accepts: got %0d expected 5", idx);
    else passed++;
    guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 20) begin step(); guard++; end
    total++;
    if (q.size() != 0) $display("FAIL bp_drain: got %0d pending expected 0", q.size());
    else passed++;
  endtask

  task automatic fill_three();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(WIDTH'(16'h0111 * (i + 1)), 16'h0000, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_silence(input string name);
    logic seen = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin step(); if (out_valid) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) $display("FAIL %s: got stale output expected none", name);
    else passed++;
  endtask

  task automatic test_flush();
    fill_three();
    set_op(16'h0444, 16'h0000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    flush    = 1'b1;
    out_ready = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", out_valid);
    else passed++;
    expect_silence("flush_stale");
    run_one("post_flush", 16'h0F00, 16'h0100, 1'b0, 1'b0, 1'b0, {17'h01000, 8'h00, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_reset_midflight();
    fill_three();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if ({out_valid, observed()} !== '0)
      $display("FAIL async_reset: got %h expected 0", {out_valid, observed()});
    else passed++;
    step();
    step();
    reset_n = 1'b1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    else passed++;
    expect_silence("reset_stale");
    run_one("post_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, {17'h01000, 8'h0B, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] p, a;
    int guard;
    for (int c = 0; c < 400; c++) begin
      p = WIDTH'($urandom_range(0, 16'hFFFF));
      case ($urandom_range(0, 3))
        0:       a = p + WIDTH'($urandom_range(0, 3)) - WIDTH'(1);
        1:       a = WIDTH'($urandom_range(0, 16'h00FF));
        default: a = WIDTH'($urandom_range(0, 16'hFFFF));
      endcase
      set_op(p, a, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 20) begin step(); guard++; end
    total++;
    if (q.size() != 0) $display("FAIL rand_drain: got %0d pending expected 0", q.size());
    else passed++;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    set_op('0, '0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
